ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Registered RV32I main-control unit for the 5-stage pipeline. Decodes the ID-stage
//  opcode into an 11-bit control word, then carries the word through the ID/EX,
//  EX/MEM and MEM/WB control registers. Each stage's signals are presented
//  cycle-aligned with its datapath stage.
//  Also handles pipeline flushes, flags illegal opcodes, and counts illegal opcodes
//  with a saturating counter. Replaces the flat combinational decoder.
// PARAMETERS
//  OPW       7   opcode width (instr[6:0])
//  CNT_W     16  illegal-opcode counter width
//  ENABLE_U  0   1: decode LUI (0110111) as a legal opcode; 0: LUI is illegal
// PORTS
//  clk            in   1      pipeline clock, rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  instr_valid_i  in   1      ID-stage instruction is real (0 = bubble)
//  op_i           in   OPW    ID-stage opcode
//  flush_e_i      in   1      load bubble into ID/EX at next edge (load-use, taken branch)
//  ex_alusrc_o    out  1      EX: ALU B operand select (1 = immediate)
//  ex_aluop_o     out  2      EX: to aludec
//  ex_immsrc_o    out  2      EX: immediate format
//  ex_branch_o    out  1      EX: conditional branch
//  ex_jump_o      out  1      EX: JAL
//  ex_illegal_o   out  1      EX: illegal opcode in EX this cycle
//  mem_memwrite_o out  1      MEM: store enable
//  wb_regwrite_o  out  1      WB: register-file write enable
//  wb_resultsrc_o out  2      WB: result select (00 ALU, 01 mem, 10 PC+4)
//  illegal_cnt_o  out  CNT_W  saturating count of illegal opcodes that reached EX
// BEHAVIOUR
//  Control word {RegWrite,ImmSrc[1:0],ALUSrc,MemWrite,ResultSrc[1:0],Branch,ALUOp[1:0],Jump}:
//   0110011 R      1_xx_0_0_00_0_10_0   | 0010011 I-ALU  1_00_1_0_00_0_10_0
//   0000011 load   1_00_1_0_01_0_00_0   | 0100011 store  0_01_1_1_xx_0_00_0
//   1100011 branch 0_10_0_0_xx_1_01_0   | 1101111 jal    1_11_x_0_10_0_xx_1
//   0110111 lui (ENABLE_U=1 only) 1_00_1_0_00_0_11_0; x fields drive 0
//  Any other opcode with instr_valid_i=1: illegal. Control word is all-zero and the
//   illegal bit is set, so an illegal instruction never writes registers or memory.
//  Decode is combinational; the first register is ID/EX. Latency from op_i:
//   EX outputs 1 cycle, MEM 2 cycles, WB 3 cycles.
//  ID/EX next value, in priority order:
//   reset -> 0; flush_e_i -> 0 (bubble);
//   instr_valid_i=0 -> 0; otherwise the decoded word and illegal bit.
//  EX/MEM and MEM/WB always advance. No stall input, because a bubble is inserted by flush.
//   Only the fields that later stages consume are stored: MEM {MemWrite,RegWrite,ResultSrc};
//   WB {RegWrite,ResultSrc}.
//  Counter: +1 on each cycle where ex_illegal_o=1. Saturates at 2^CNT_W-1, no wrap.
//  Simultaneous flush_e_i with an illegal opcode in ID: flush wins, so no flag and no count.
//  Reset mid-operation: every register and every output goes to 0 immediately (async),
//   including illegal_cnt_o.
//   First post-reset edge loads ID/EX only; MEM and WB outputs stay 0 until filled.
// STRUCTURE
//  Package ctrl_pkg:
//   - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI)
//   - ctrl_word_t packed struct (11 bits)
//   - aluop_t enum (ADD=00, SUB=01, FUNCT=10, PASSB=11)
//   - resultsrc_t enum
//  Sub-module ctrl_rom: combinational op -> {ctrl_word_t, illegal}, parametrised by ENABLE_U.
//  ctrl_pipe holds only the three stage registers and the counter.
// TESTING
//  1 Stream R, I-ALU, load, store, branch, jal with valid=1 -> each EX word matches the
//    table 1 cycle later; wb_regwrite_o=1,1,1,0,0,1 three cycles later; resultsrc 00,00,01,-,-,10.
//  2 Load, then flush_e_i=1 for 1 cycle with an R op -> EX all-zero for that cycle;
//    MEM/WB carry the bubble 1 and 2 cycles later.
//  3 op=1111111, valid=1 -> ex_illegal_o=1 for one cycle, all EX/MEM/WB enables 0,
//    illegal_cnt_o 0->1.
//  4 LUI with ENABLE_U=0 -> illegal and counted; with ENABLE_U=1 -> ALUOp=11,
//    ALUSrc=1, wb_regwrite_o=1 at cycle 3.
//  5 CNT_W=2, five illegal ops -> count 1,2,3,3,3; illegal op with simultaneous
//    flush -> no change.
//  6 Assert reset mid-stream (between edges) -> all outputs 0 before next edge;
//    release -> first valid op appears at EX after 1 edge, and at WB after 3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared RV32I main-control definitions: opcodes, control-word layout and field encodings.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_PASSB = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultsrc_t;

    // Field order fixes the 11-bit packing, MSB first.
    typedef struct packed {
        logic       regwrite;
        logic [1:0] immsrc;
        logic       alusrc;
        logic       memwrite;
        resultsrc_t resultsrc;
        logic       branch;
        aluop_t     aluop;
        logic       jump;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_rom.sv
// Combinational opcode decoder: produces the control word and an illegal-opcode flag.
module ctrl_rom
    import ctrl_pkg::*;
#(
    parameter int OPW      = 7,
    parameter int ENABLE_U = 0
) (
    input  logic [OPW-1:0] op,
    output ctrl_word_t     word,
    output logic           illegal
);

    // Unlisted fields keep the all-zero default, so illegal opcodes decode to a harmless word.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OP_R: begin
                word.regwrite = 1'b1;
                word.aluop    = ALU_FUNCT;
            end
            OP_I: begin
                word.regwrite = 1'b1;
                word.alusrc   = 1'b1;
                word.aluop    = ALU_FUNCT;
            end
            OP_LOAD: begin
                word.regwrite  = 1'b1;
                word.alusrc    = 1'b1;
                word.resultsrc = RES_MEM;
                word.aluop     = ALU_ADD;
            end
            OP_STORE: begin
                word.immsrc   = 2'b01;
                word.alusrc   = 1'b1;
                word.memwrite = 1'b1;
                word.aluop    = ALU_ADD;
            end
            OP_BRANCH: begin
                word.immsrc = 2'b10;
                word.branch = 1'b1;
                word.aluop  = ALU_SUB;
            end
            OP_JAL: begin
                word.regwrite  = 1'b1;
                word.immsrc    = 2'b11;
                word.resultsrc = RES_PC4;
                word.jump      = 1'b1;
            end
            OP_LUI: begin
                if (ENABLE_U != 0) begin
                    word.regwrite = 1'b1;
                    word.alusrc   = 1'b1;
                    word.aluop    = ALU_PASSB;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Registered main control: decodes in ID, then carries the control word through ID/EX,
// EX/MEM and MEM/WB, and keeps a saturating count of illegal opcodes reaching EX.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OPW      = 7,
    parameter int CNT_W    = 16,
    parameter int ENABLE_U = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid_i,
    input  logic [OPW-1:0]   op_i,
    input  logic             flush_e_i,
    output logic             ex_alusrc_o,
    output logic [1:0]       ex_aluop_o,
    output logic [1:0]       ex_immsrc_o,
    output logic             ex_branch_o,
    output logic             ex_jump_o,
    output logic             ex_illegal_o,
    output logic             mem_memwrite_o,
    output logic             wb_regwrite_o,
    output logic [1:0]       wb_resultsrc_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    ctrl_word_t       dec_word;
    logic             dec_illegal;

    ctrl_word_t       idex_q;
    logic             idex_ill_q;
    logic             mem_memwrite_q;
    logic             mem_regwrite_q;
    resultsrc_t       mem_resultsrc_q;
    logic             wb_regwrite_q;
    resultsrc_t       wb_resultsrc_q;
    logic [CNT_W-1:0] cnt_q;

    ctrl_rom #(
        .OPW      (OPW),
        .ENABLE_U (ENABLE_U)
    ) u_rom (
        .op      (op_i),
        .word    (dec_word),
        .illegal (dec_illegal)
    );

    // Flush outranks everything but reset, so a flushed illegal op is neither flagged nor counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q     <= '0;
            idex_ill_q <= 1'b0;
        end else if (flush_e_i || !instr_valid_i) begin
            idex_q     <= '0;
            idex_ill_q <= 1'b0;
        end else begin
            idex_q     <= dec_word;
            idex_ill_q <= dec_illegal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_memwrite_q  <= 1'b0;
            mem_regwrite_q  <= 1'b0;
            mem_resultsrc_q <= RES_ALU;
            wb_regwrite_q   <= 1'b0;
            wb_resultsrc_q  <= RES_ALU;
        end else begin
            mem_memwrite_q  <= idex_q.memwrite;
            mem_regwrite_q  <= idex_q.regwrite;
            mem_resultsrc_q <= idex_q.resultsrc;
            wb_regwrite_q   <= mem_regwrite_q;
            wb_resultsrc_q  <= mem_resultsrc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (idex_ill_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ex_alusrc_o    = idex_q.alusrc;
    assign ex_aluop_o     = idex_q.aluop;
    assign ex_immsrc_o    = idex_q.immsrc;
    assign ex_branch_o    = idex_q.branch;
    assign ex_jump_o      = idex_q.jump;
    assign ex_illegal_o   = idex_ill_q;
    assign mem_memwrite_o = mem_memwrite_q;
    assign wb_regwrite_o  = wb_regwrite_q;
    assign wb_resultsrc_o = wb_resultsrc_q;
    assign illegal_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: three instances (default, LUI enabled, 2-bit counter) share stimulus.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid_i = 1'b0;
    logic       flush_e_i = 1'b0;
    logic [6:0] op_i = '0;

    int checks = 0;
    int failures = 0;

    logic a_alusrc, a_branch, a_jump, a_illegal, a_memwrite, a_regwrite;
    logic [1:0] a_aluop, a_immsrc, a_resultsrc;
    logic [15:0] a_cnt;
    logic u_alusrc, u_branch, u_jump, u_illegal, u_memwrite, u_regwrite;
    logic [1:0] u_aluop, u_immsrc, u_resultsrc;
    logic [15:0] u_cnt;
    logic c_alusrc, c_branch, c_jump, c_illegal, c_memwrite, c_regwrite;
    logic [1:0] c_aluop, c_immsrc, c_resultsrc;
    logic [1:0] c_cnt;

    logic [6:0] ex_a;
    logic [6:0] ex_u;
    logic [6:0] ex_c;
    assign ex_a = {a_immsrc, a_alusrc, a_branch, a_aluop, a_jump};
    assign ex_u = {u_immsrc, u_alusrc, u_branch, u_aluop, u_jump};
    assign ex_c = {c_immsrc, c_alusrc, c_branch, c_aluop, c_jump};

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .op_i(op_i), .flush_e_i(flush_e_i),
        .ex_alusrc_o(a_alusrc), .ex_aluop_o(a_aluop), .ex_immsrc_o(a_immsrc), .ex_branch_o(a_branch),
        .ex_jump_o(a_jump), .ex_illegal_o(a_illegal), .mem_memwrite_o(a_memwrite),
        .wb_regwrite_o(a_regwrite), .wb_resultsrc_o(a_resultsrc), .illegal_cnt_o(a_cnt)
    );

    ctrl_pipe #(.ENABLE_U(1)) dut_u (
        .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .op_i(op_i), .flush_e_i(flush_e_i),
        .ex_alusrc_o(u_alusrc), .ex_aluop_o(u_aluop), .ex_immsrc_o(u_immsrc), .ex_branch_o(u_branch),
        .ex_jump_o(u_jump), .ex_illegal_o(u_illegal), .mem_memwrite_o(u_memwrite),
        .wb_regwrite_o(u_regwrite), .wb_resultsrc_o(u_resultsrc), .illegal_cnt_o(u_cnt)
    );

    ctrl_pipe #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .op_i(op_i), .flush_e_i(flush_e_i),
        .ex_alusrc_o(c_alusrc), .ex_aluop_o(c_aluop), .ex_immsrc_o(c_immsrc), .ex_branch_o(c_branch),
        .ex_jump_o(c_jump), .ex_illegal_o(c_illegal), .mem_memwrite_o(c_memwrite),
        .wb_regwrite_o(c_regwrite), .wb_resultsrc_o(c_resultsrc), .illegal_cnt_o(c_cnt)
    );

    // EX-visible slice of an 11-bit table word {RegWrite,ImmSrc,ALUSrc,MemWrite,ResultSrc,Branch,ALUOp,Jump}.
    function automatic logic [6:0] exv(input logic [10:0] w);
        return {w[9:8], w[7], w[3], w[2:1], w[0]};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        instr_valid_i = 1'b0;
        flush_e_i = 1'b0;
        op_i = '0;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_valid_i = 1'b1;
        op_i = 7'b0110011;
        #1;
        checks++;
        if ({ex_a, a_illegal, a_memwrite, a_regwrite, a_resultsrc, a_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_initial got ex=%b ill=%b mw=%b rw=%b rs=%b cnt=%0d exp all 0",
                     ex_a, a_illegal, a_memwrite, a_regwrite, a_resultsrc, a_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if ({ex_a, a_illegal, a_memwrite, a_regwrite, a_resultsrc, a_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_held got ex=%b ill=%b rw=%b cnt=%0d exp all 0", ex_a, a_illegal, a_regwrite, a_cnt);
        end
        do_reset();
    endtask

    task automatic test_stream();
        logic [6:0]  ops[6] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
        logic [10:0] w[6]   = '{11'b1_00_0_0_00_0_10_0, 11'b1_00_1_0_00_0_10_0, 11'b1_00_1_0_01_0_00_0,
                                11'b0_01_1_1_00_0_00_0, 11'b0_10_0_0_00_1_01_0, 11'b1_11_0_0_10_0_00_1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin
                instr_valid_i = 1'b1;
                op_i = ops[c];
            end else begin
                instr_valid_i = 1'b0;
                op_i = '0;
            end
            @(posedge clk); #1;
            if (c < 6) begin
                checks++;
                if (ex_a !== exv(w[c]) || a_illegal !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_ex[%0d] got=%b ill=%b exp=%b ill=0", c, ex_a, a_illegal, exv(w[c]));
                end
            end
            if (c >= 1 && c <= 6) begin
                checks++;
                if (a_memwrite !== w[c-1][6]) begin
                    failures++;
                    $display("FAIL stream_mem[%0d] got=%b exp=%b", c - 1, a_memwrite, w[c-1][6]);
                end
            end
            if (c >= 2) begin
                checks++;
                if (a_regwrite !== w[c-2][10] || a_resultsrc !== w[c-2][5:4]) begin
                    failures++;
                    $display("FAIL stream_wb[%0d] got rw=%b rs=%b exp rw=%b rs=%b",
                             c - 2, a_regwrite, a_resultsrc, w[c-2][10], w[c-2][5:4]);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        instr_valid_i = 1'b1;
        op_i = 7'b0000011;
        @(posedge clk); #1;
        op_i = 7'b0110011;
        flush_e_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ex_a !== 7'b0 || a_illegal !== 1'b0) begin
            failures++;
            $display("FAIL flush_ex got=%b ill=%b exp=0000000 ill=0", ex_a, a_illegal);
        end
        flush_e_i = 1'b0;
        instr_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_memwrite !== 1'b0 || a_regwrite !== 1'b1 || a_resultsrc !== 2'b01) begin
            failures++;
            $display("FAIL flush_mem_bubble got mw=%b wb_rw=%b wb_rs=%b exp mw=0 rw=1 rs=01",
                     a_memwrite, a_regwrite, a_resultsrc);
        end
        @(posedge clk); #1;
        checks++;
        if (a_regwrite !== 1'b0 || a_resultsrc !== 2'b00) begin
            failures++;
            $display("FAIL flush_wb_bubble got rw=%b rs=%b exp rw=0 rs=00", a_regwrite, a_resultsrc);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        instr_valid_i = 1'b1;
        op_i = 7'b1111111;
        @(posedge clk); #1;
        checks++;
        if (a_illegal !== 1'b1 || ex_a !== 7'b0 || a_cnt !== 16'd0) begin
            failures++;
            $display("FAIL illegal_ex got ill=%b ex=%b cnt=%0d exp ill=1 ex=0 cnt=0", a_illegal, ex_a, a_cnt);
        end
        instr_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_illegal !== 1'b0 || a_cnt !== 16'd1 || a_memwrite !== 1'b0) begin
            failures++;
            $display("FAIL illegal_cnt got ill=%b cnt=%0d mw=%b exp ill=0 cnt=1 mw=0", a_illegal, a_cnt, a_memwrite);
        end
        @(posedge clk); #1;
        checks++;
        if (a_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL illegal_wb got rw=%b exp 0", a_regwrite);
        end
    endtask

    task automatic test_lui();
        do_reset();
        instr_valid_i = 1'b1;
        op_i = 7'b0110111;
        @(posedge clk); #1;
        checks++;
        if (a_illegal !== 1'b1 || ex_a !== 7'b0) begin
            failures++;
            $display("FAIL lui_off_ex got ill=%b ex=%b exp ill=1 ex=0", a_illegal, ex_a);
        end
        checks++;
        if (u_illegal !== 1'b0 || ex_u !== exv(11'b1_00_1_0_00_0_11_0)) begin
            failures++;
            $display("FAIL lui_on_ex got ill=%b ex=%b exp ill=0 ex=%b", u_illegal, ex_u, exv(11'b1_00_1_0_00_0_11_0));
        end
        instr_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_cnt !== 16'd1 || u_cnt !== 16'd0) begin
            failures++;
            $display("FAIL lui_cnt got off=%0d on=%0d exp off=1 on=0", a_cnt, u_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (u_regwrite !== 1'b1 || u_resultsrc !== 2'b00 || a_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL lui_wb got on_rw=%b on_rs=%b off_rw=%b exp 1 00 0", u_regwrite, u_resultsrc, a_regwrite);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_c;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            instr_valid_i = 1'b1;
            op_i = 7'b1111111;
            @(posedge clk); #1;
            if (i >= 1) begin
                exp_c = (i > 3) ? 2'd3 : 2'(i);
                checks++;
                if (c_cnt !== exp_c) begin
                    failures++;
                    $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, c_cnt, exp_c);
                end
            end
        end
        instr_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (c_cnt !== 2'd3 || a_cnt !== 16'd5) begin
            failures++;
            $display("FAIL sat_final got c=%0d a=%0d exp c=3 a=5", c_cnt, a_cnt);
        end
        instr_valid_i = 1'b1;
        flush_e_i = 1'b1;
        op_i = 7'b1111111;
        @(posedge clk); #1;
        checks++;
        if (a_illegal !== 1'b0 || c_illegal !== 1'b0) begin
            failures++;
            $display("FAIL flush_illegal_ex got a=%b c=%b exp 0", a_illegal, c_illegal);
        end
        flush_e_i = 1'b0;
        instr_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_cnt !== 16'd5 || c_cnt !== 2'd3) begin
            failures++;
            $display("FAIL flush_illegal_cnt got a=%0d c=%0d exp a=5 c=3", a_cnt, c_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        instr_valid_i = 1'b1;
        op_i = 7'b1111111;
        @(posedge clk); #1;
        op_i = 7'b1101111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (a_regwrite !== 1'b1 || a_jump !== 1'b1 || a_cnt !== 16'd1) begin
            failures++;
            $display("FAIL mid_prefill got rw=%b jump=%b cnt=%0d exp 1 1 1", a_regwrite, a_jump, a_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ex_a, a_illegal, a_memwrite, a_regwrite, a_resultsrc, a_cnt} !== '0) begin
            failures++;
            $display("FAIL mid_async got ex=%b ill=%b mw=%b rw=%b rs=%b cnt=%0d exp all 0",
                     ex_a, a_illegal, a_memwrite, a_regwrite, a_resultsrc, a_cnt);
        end
        #1;
        reset = 1'b0;
        op_i = 7'b0110011;
        @(posedge clk); #1;
        checks++;
        if (ex_a !== exv(11'b1_00_0_0_00_0_10_0) || a_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL mid_first_ex got ex=%b rw=%b exp ex=%b rw=0", ex_a, a_regwrite, exv(11'b1_00_0_0_00_0_10_0));
        end
        instr_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL mid_wb_early got rw=%b exp 0", a_regwrite);
        end
        @(posedge clk); #1;
        checks++;
        if (a_regwrite !== 1'b1 || a_resultsrc !== 2'b00) begin
            failures++;
            $display("FAIL mid_wb got rw=%b rs=%b exp rw=1 rs=00", a_regwrite, a_resultsrc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_flush();
        test_illegal();
        test_lui();
        test_saturate();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
